// File: rtl/window33_linebuf.sv
// 3x3 window generator for the convolution kernel stage.
// Takes a raster-order pixel stream and keeps the two previous lines in chained line buffers.
// A 3x3 shift window is built from those lines. Once line >= 2 and col >= 2, each accepted
// pixel produces one window as three packed row words. Rows are top (y-2), middle (y-1) and
// bottom (y). Within a row word the oldest column is in the most significant slot.
// Optional feature: define WINDOW33_EOF_EN to add out_eof, which flags the last window of a frame.
module window33_linebuf #(
  parameter int unsigned PIXEL_W = 16,
  parameter int unsigned IMG_W   = 640,
  parameter int unsigned IMG_H   = 480
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PIXEL_W-1:0]   in_pixel,
  input  logic                 in_sof,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3*PIXEL_W-1:0] out_row1,
  output logic [3*PIXEL_W-1:0] out_row2,
  output logic [3*PIXEL_W-1:0] out_row3
`ifdef WINDOW33_EOF_EN
  ,
  output logic                 out_eof
`endif
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned LW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned RW = 3 * PIXEL_W;

  localparam logic [CW-1:0] ColLast  = CW'(IMG_W - 1);
  localparam logic [LW-1:0] LineLast = LW'(IMG_H - 1);
  localparam logic [CW-1:0] ColTwo   = CW'(2);
  localparam logic [LW-1:0] LineTwo  = LW'(2);

  // Line buffers: lb1 holds line y-1, lb2 holds line y-2 (at the current column).
  logic [PIXEL_W-1:0] lb1_mem [IMG_W];
  logic [PIXEL_W-1:0] lb2_mem [IMG_W];
  logic [PIXEL_W-1:0] lb1_rd, lb2_rd;

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [LW-1:0] line_q, line_d, cur_line;

  logic [RW-1:0] win1_q, win2_q, win3_q;
  logic [RW-1:0] win1_d, win2_d, win3_d;

  logic          out_valid_q;
  logic [RW-1:0] row1_q, row2_q, row3_q;

  logic accept;
  logic load;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_row1  = row1_q;
  assign out_row2  = row2_q;
  assign out_row3  = row3_q;

  // Position of the incoming pixel; start of frame overrides the counters.
  always_comb begin
    cur_col  = col_q;
    cur_line = line_q;
    if (in_sof) begin
      cur_col  = '0;
      cur_line = '0;
    end
  end

  assign lb1_rd = lb1_mem[cur_col];
  assign lb2_rd = lb2_mem[cur_col];

  // A window is complete once two lines and two columns of history exist.
  assign load = accept && (cur_line >= LineTwo) && (cur_col >= ColTwo);

  // Next window: shift left and append the new column; a resync drops the old columns.
  always_comb begin
    win1_d = {win1_q[2*PIXEL_W-1:0], lb2_rd};
    win2_d = {win2_q[2*PIXEL_W-1:0], lb1_rd};
    win3_d = {win3_q[2*PIXEL_W-1:0], in_pixel};
    if (in_sof) begin
      win1_d = {{(2*PIXEL_W){1'b0}}, lb2_rd};
      win2_d = {{(2*PIXEL_W){1'b0}}, lb1_rd};
      win3_d = {{(2*PIXEL_W){1'b0}}, in_pixel};
    end
  end

  // Next raster position after the accepted pixel, wrapping at end of line and frame.
  always_comb begin
    col_d  = cur_col + CW'(1);
    line_d = cur_line;
    if (cur_col == ColLast) begin
      col_d  = '0;
      line_d = (cur_line == LineLast) ? '0 : cur_line + LW'(1);
    end
  end

  // Line buffer RAMs: lb1 captures the pixel, lb2 captures what lb1 held at this column.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_mem[cur_col] <= in_pixel;
      lb2_mem[cur_col] <= lb1_rd;
    end
  end

  // Counters and the shift window advance on every accepted pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      line_q <= '0;
      win1_q <= '0;
      win2_q <= '0;
      win3_q <= '0;
    end else if (accept) begin
      col_q  <= col_d;
      line_q <= line_d;
      win1_q <= win1_d;
      win2_q <= win2_d;
      win3_q <= win3_d;
    end
  end

  // Output register: load a new window, otherwise hold until the downstream takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      row1_q      <= '0;
      row2_q      <= '0;
      row3_q      <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      row1_q      <= win1_d;
      row2_q      <= win2_d;
      row3_q      <= win3_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef WINDOW33_EOF_EN
  logic out_eof_q;

  assign out_eof = out_eof_q;

  // End-of-frame flag travels with the window it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_eof_q <= 1'b0;
    end else if (load) begin
      out_eof_q <= (cur_line == LineLast) && (cur_col == ColLast);
    end else if (out_ready) begin
      out_eof_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_window33_linebuf.sv
// Bench for window33_linebuf on a 4x4 image. A full-image reference model predicts each
// window when its pixel is driven; windows are compared in order as the DUT hands them off.
module tb_window33_linebuf;

  localparam int unsigned PW = 16;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;

  typedef struct packed {
    logic [9*PW-1:0] rows;
    logic            eof;
  } exp_t;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [PW-1:0]   in_pixel;
  logic            in_sof;
  logic            out_valid;
  logic            out_ready;
  logic [3*PW-1:0] out_row1, out_row2, out_row3;
`ifdef WINDOW33_EOF_EN
  logic            out_eof;
`endif

  window33_linebuf #(
    .PIXEL_W (PW),
    .IMG_W   (W),
    .IMG_H   (H)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row1  (out_row1),
    .out_row2  (out_row2),
    .out_row3  (out_row3)
`ifdef WINDOW33_EOF_EN
    ,
    .out_eof   (out_eof)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  exp_t            exp_q [$];
  logic [9*PW-1:0] seen  [$];
  logic [PW-1:0]   img   [H][W];
  int              mx = 0;
  int              my = 0;
  logic            stall_req = 1'b0;

  task automatic check(input string tag, input logic [9*PW-1:0] got, input logic [9*PW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9*PW-1:0] pack9(input int a, b, c, d, e, f, g, h, i);
    return {PW'(a), PW'(b), PW'(c), PW'(d), PW'(e), PW'(f), PW'(g), PW'(h), PW'(i)};
  endfunction

  // Reference: keep the whole current frame and read the 3x3 neighbourhood directly.
  task automatic model_accept(input logic [PW-1:0] p, input logic sof);
    exp_t e;
    if (sof) begin
      mx = 0;
      my = 0;
    end
    img[my][mx] = p;
    if (my >= 2 && mx >= 2) begin
      e.rows = {img[my-2][mx-2], img[my-2][mx-1], img[my-2][mx],
                img[my-1][mx-2], img[my-1][mx-1], img[my-1][mx],
                img[my][mx-2],   img[my][mx-1],   img[my][mx]};
      e.eof  = (my == H - 1) && (mx == W - 1);
      exp_q.push_back(e);
    end
    mx++;
    if (mx == W) begin
      mx = 0;
      my = (my == H - 1) ? 0 : my + 1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the pixel has been accepted.
  task automatic send(input int p, input logic sof);
    int b = 0;
    in_valid = 1'b1;
    in_pixel = PW'(p);
    in_sof   = sof;
    @(negedge clk);
    while (!in_ready && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (!in_ready) check("in_ready_timeout", {{(9*PW-1){1'b0}}, in_ready}, 1);
    else model_accept(PW'(p), sof);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int base, input logic sof_first);
    for (int i = 0; i < W * H; i++) send(base + i, sof_first && (i == 0));
  endtask

  task automatic idle_sof(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    in_sof = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      @(posedge clk);
      b++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  // Scoreboard: compare each window at the moment it is handed off.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      seen.push_back({out_row1, out_row2, out_row3});
      if (exp_q.size() == 0) begin
        check("extra_window", {{(9*PW-1){1'b0}}, out_valid}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("window", {out_row1, out_row2, out_row3}, e.rows);
`ifdef WINDOW33_EOF_EN
        check("eof", {{(9*PW-1){1'b0}}, out_eof}, {{(9*PW-1){1'b0}}, e.eof});
`endif
      end
    end
  end

  // Downstream sink: normally ready, stalls 5 cycles on request when a window shows up.
  initial begin
    logic [9*PW-1:0] held;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_req && out_valid) begin
        stall_req = 1'b0;
        out_ready = 1'b0;
        held = {out_row1, out_row2, out_row3};
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_in_ready", {{(9*PW-1){1'b0}}, in_ready}, 0);
          check("stall_valid", {{(9*PW-1){1'b0}}, out_valid}, 1);
          check("stall_rows", {out_row1, out_row2, out_row3}, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_pixel = '0;
    in_sof   = 1'b0;
    #2;
    check("rst_valid", {{(9*PW-1){1'b0}}, out_valid}, 0);
    check("rst_rows", {out_row1, out_row2, out_row3}, 0);
    check("rst_in_ready", {{(9*PW-1){1'b0}}, in_ready}, 1);
`ifdef WINDOW33_EOF_EN
    check("rst_eof", {{(9*PW-1){1'b0}}, out_eof}, 0);
`endif
    #20;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic frame, with a stray in_sof while in_valid is low in the middle.
    base = seen.size();
    for (int i = 0; i < W * H; i++) begin
      send(i, i == 0);
      if (i == 7) idle_sof(2);
    end
    drain();
    check("basic_count", seen.size() - base, 4);
    check("basic_first", seen[base], pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
    check("basic_last", seen[base+3], pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));

    // Backpressure on the first window.
    base = seen.size();
    stall_req = 1'b1;
    send_frame(0, 1'b1);
    drain();
    check("bp_count", seen.size() - base, 4);
    check("bp_second", seen[base+1], pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));

    // Back-to-back frames.
    base = seen.size();
    send_frame(0, 1'b1);
    send_frame(100, 1'b1);
    drain();
    check("b2b_count", seen.size() - base, 8);
    check("b2b_f2_first", seen[base+4], pack9(100, 101, 102, 104, 105, 106, 108, 109, 110));

    // Resync: sof arrives on the 7th pixel of a frame.
    base = seen.size();
    for (int i = 0; i < 6; i++) send(50 + i, i == 0);
    send_frame(200, 1'b1);
    drain();
    check("resync_count", seen.size() - base, 4);
    check("resync_first", seen[base], pack9(200, 201, 202, 204, 205, 206, 208, 209, 210));

    // Reset while a window is pending, then a frame without sof.
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) send(i, i == 0);
    @(negedge clk);
    check("pre_rst_valid", {{(9*PW-1){1'b0}}, out_valid}, 1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {{(9*PW-1){1'b0}}, out_valid}, 0);
    check("mid_rst_rows", {out_row1, out_row2, out_row3}, 0);
    check("mid_rst_in_ready", {{(9*PW-1){1'b0}}, in_ready}, 1);
    exp_q.delete();
    mx = 0;
    my = 0;
    #5;
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    base = seen.size();
    send_frame(60, 1'b0);
    drain();
    check("post_rst_count", seen.size() - base, 4);
    check("post_rst_first", seen[base], pack9(60, 61, 62, 64, 65, 66, 68, 69, 70));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
